// File: rtl/rand_pkg.sv
// Shared definitions for the random-number scheduler: default seed, generator
// state payload, scheduler state encoding, default sizes and width helpers.
package rand_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam logic [31:0] SEED_X = 32'd123456789;
  localparam logic [31:0] SEED_Y = 32'd362436069;
  localparam logic [31:0] SEED_Z = 32'd521288629;
  localparam logic [31:0] SEED_W = 32'd88675123;

  // Full xorshift128 state; also the layout of the seed staging register.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } xs_state_t;

  localparam xs_state_t SEED_DEFAULT = '{x: SEED_X, y: SEED_Y, z: SEED_Z, w: SEED_W};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_WARMUP = 1'b1
  } sched_state_t;

  // FIFO address width = clog2(FIFO_DEPTH), kept at least 1 bit.
  function automatic int unsigned fifo_aw(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Round-robin pointer width = clog2(NUM_REQ), kept at least 1 bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rand_sched_if.sv
// Requester/CPU-side bundle of the random scheduler.
//   req/ack/rdata        : per-requester request level, grant pulse, granted word
//   seed_wr/addr/data/go : seed staging writes and commit
//   seed_err/ready/busy  : status back to the CPU
// master = requester/CPU side, slave = scheduler.
interface rand_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [31:0]        rdata;
  logic               seed_wr;
  logic [1:0]         seed_addr;
  logic [31:0]        seed_data;
  logic               seed_go;
  logic               seed_err;
  logic               ready;
  logic               busy;

  modport master (
    output req, seed_wr, seed_addr, seed_data, seed_go,
    input  ack, rdata, seed_err, ready, busy
  );

  modport slave (
    input  req, seed_wr, seed_addr, seed_data, seed_go,
    output ack, rdata, seed_err, ready, busy
  );
endinterface

// File: rtl/rand_xs128_core.sv
// xorshift128 generator with step enable and parallel seed load.
//   clk, reset : clock, async active-high reset (loads default seed)
//   step_en    : advance one step (x,y,z,w <= y,z,w,w')
//   load_en    : load load_val (wins over step_en)
//   w_next_c   : w' of the current state (combinational)
module rand_xs128_core
  import rand_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step_en,
  input  logic        load_en,
  input  xs_state_t   load_val,
  output logic [31:0] w_next_c
);

  xs_state_t   s_q, s_d;
  logic [31:0] t_c;

  // Same datapath as the rand instruction.
  always_comb begin
    t_c      = s_q.x ^ (s_q.x << 11);
    w_next_c = s_q.w ^ (s_q.w >> 19) ^ t_c ^ (t_c >> 8);
    s_d      = s_q;
    if (load_en) begin
      s_d = load_val;
    end else if (step_en) begin
      s_d = '{x: s_q.y, y: s_q.z, z: s_q.w, w: w_next_c};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_q <= SEED_DEFAULT;
    else       s_q <= s_d;
  end

endmodule

// File: rtl/rand_sched.sv
// Shared random-number service: one xorshift128 generator feeding a prefetch
// FIFO, words granted round-robin to NUM_REQ requesters, CPU seed/warm-up.
//   clk, reset : clock, async active-high reset
//   bus        : rand_sched_if slave (req/ack/rdata, seed staging, status)
module rand_sched
  import rand_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned WARMUP_STEPS = 0
) (
  input  logic clk,
  input  logic reset,
  rand_sched_if.slave bus
);

  localparam int unsigned AW = fifo_aw(FIFO_DEPTH);
  localparam int unsigned PW = ptr_w(NUM_REQ);
  localparam int unsigned CW = AW + 1;

  sched_state_t       state_q, state_d;
  logic [7:0]         warm_q, warm_d;
  xs_state_t          stg_q, stg_d;
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               seed_err_q, seed_err_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               step_c, push_c, pop_c, found_c;
  logic [PW-1:0]      idx_c, cand_c;
  xs_state_t          load_val_c;
  logic [31:0]        w_next_c;

  rand_xs128_core u_core (
    .clk      (clk),
    .reset    (reset),
    .step_en  (step_c),
    .load_en  (bus.seed_go),
    .load_val (load_val_c),
    .w_next_c (w_next_c)
  );

  // Round-robin search from rr_q; a requester still seeing its ack is skipped.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand_c  = '0;
    if ((state_q == ST_RUN) && (cnt_q != '0) && !bus.seed_go) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_c = PW'((32'(rr_q) + k) % NUM_REQ);
        if (!found_c && bus.req[cand_c] && !ack_q[cand_c]) begin
          found_c = 1'b1;
          idx_c   = cand_c;
        end
      end
    end
  end

  // Next-state: seed commit, warm-up countdown, FIFO push/pop and grant.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    stg_d      = stg_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    seed_err_d = 1'b0;
    step_c     = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    // Commit always sees the pre-write staging value.
    load_val_c = (stg_q == '0) ? SEED_DEFAULT : stg_q;

    if (bus.seed_wr) begin
      unique case (bus.seed_addr)
        2'd0: stg_d.x = bus.seed_data;
        2'd1: stg_d.y = bus.seed_data;
        2'd2: stg_d.z = bus.seed_data;
        2'd3: stg_d.w = bus.seed_data;
      endcase
    end

    if (bus.seed_go) begin
      wr_d       = '0;
      rd_d       = '0;
      cnt_d      = '0;
      seed_err_d = (stg_q == '0);
      if (WARMUP_STEPS > 0) begin
        state_d = ST_WARMUP;
        warm_d  = 8'(WARMUP_STEPS);
      end else begin
        state_d = ST_RUN;
        warm_d  = '0;
      end
    end else if (state_q == ST_WARMUP) begin
      step_c = 1'b1;
      if (warm_q <= 8'd1) begin
        state_d = ST_RUN;
        warm_d  = '0;
      end else begin
        warm_d = warm_q - 8'd1;
      end
    end else begin
      pop_c  = found_c;
      // A full FIFO still accepts a word when the head leaves this cycle.
      push_c = (cnt_q != CW'(FIFO_DEPTH)) || pop_c;
      step_c = push_c;
      if (pop_c) begin
        ack_d[idx_c] = 1'b1;
        rdata_d      = fifo_mem[rd_q];
        rd_d         = rd_q + AW'(1);
        rr_d         = (idx_c == PW'(NUM_REQ - 1)) ? '0 : idx_c + PW'(1);
      end
      if (push_c) wr_d = wr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_c) - CW'(pop_c);
    end

    ready_d = (state_d == ST_RUN) && (cnt_d != '0);
    busy_d  = (state_d == ST_WARMUP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      warm_q     <= '0;
      stg_q      <= SEED_DEFAULT;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      seed_err_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      stg_q      <= stg_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      seed_err_q <= seed_err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_q] <= w_next_c;
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.seed_err = seed_err_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rand_sched.sv
// Bench for rand_sched: directed sequence on a default instance, warm-up and
// randomized traffic on a FIFO_DEPTH=2 / WARMUP_STEPS=3 instance, all words
// compared with a plain xorshift128 sequence model.
module tb_rand_sched;

  localparam logic [127:0] DEF_SEED = {32'd123456789, 32'd362436069,
                                       32'd521288629, 32'd88675123};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rand_sched_if #(.NUM_REQ(4)) bus_a ();
  rand_sched_if #(.NUM_REQ(4)) bus_b ();

  rand_sched #(.NUM_REQ(4), .FIFO_DEPTH(4), .WARMUP_STEPS(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  rand_sched #(.NUM_REQ(4), .FIFO_DEPTH(2), .WARMUP_STEPS(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] ma, mb, commit;
  logic [31:0]  stg_b [4];
  logic [31:0]  w, got;
  logic [3:0]   exp_ack, pend;
  int           wait_cnt [4];
  int           max_wait, lat;
  logic         exp_err;

  // Reference generator: state {x,y,z,w}, returns the new w.
  function automatic logic [31:0] xs_next(inout logic [127:0] s);
    logic [31:0] x, y, z, v, t, wn;
    x  = s[127:96];
    y  = s[95:64];
    z  = s[63:32];
    v  = s[31:0];
    t  = x ^ (x << 11);
    wn = v ^ (v >> 19) ^ t ^ (t >> 8);
    s  = {y, z, v, wn};
    return wn;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise r on instance A, wait for a grant, check ack and word, drop req.
  task automatic a_grant(input logic [3:0] r, input logic [3:0] ea, input int exp_lat,
                         input string tag, output logic [31:0] word);
    logic [31:0] mw;
    int l;
    bus_a.req = r;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while ((bus_a.ack == 4'b0) && (l < 20));
    check({tag, " ack"}, 64'(bus_a.ack), 64'(ea));
    mw = xs_next(ma);
    check({tag, " rdata"}, 64'(bus_a.rdata), 64'(mw));
    if (exp_lat > 0) check({tag, " latency"}, 64'(l), 64'(exp_lat));
    word = bus_a.rdata;
    bus_a.req = 4'b0;
  endtask

  task automatic a_seed_write(input logic [1:0] addr, input logic [31:0] d);
    bus_a.seed_wr   = 1'b1;
    bus_a.seed_addr = addr;
    bus_a.seed_data = d;
    @(negedge clk);
    bus_a.seed_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req = '0; bus_a.seed_wr = 1'b0; bus_a.seed_addr = '0; bus_a.seed_data = '0; bus_a.seed_go = 1'b0;
    bus_b.req = '0; bus_b.seed_wr = 1'b0; bus_b.seed_addr = '0; bus_b.seed_data = '0; bus_b.seed_go = 1'b0;
    ma = DEF_SEED;
    mb = DEF_SEED;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst ack", 64'(bus_a.ack), 64'(0));
    check("rst rdata", 64'(bus_a.rdata), 64'(0));
    check("rst seed_err", 64'(bus_a.seed_err), 64'(0));
    check("rst ready", 64'(bus_a.ready), 64'(0));
    check("rst busy", 64'(bus_a.busy), 64'(0));
    check("rst b busy", 64'(bus_b.busy), 64'(0));

    // First word after reset release: grant decided in the 2nd cycle
    reset = 1'b0;
    bus_a.req = 4'b0001;
    @(negedge clk);
    check("first ready", 64'(bus_a.ready), 64'(1));
    check("first no ack", 64'(bus_a.ack), 64'(0));
    @(negedge clk);
    check("first ack", 64'(bus_a.ack), 64'(4'b0001));
    check("first word", 64'(bus_a.rdata), 64'(32'd3701687786));
    void'(xs_next(ma));
    bus_a.req = 4'b0;

    a_grant(4'b0010, 4'b0010, 1, "w2", got);
    check("w2 const", 64'(got), 64'(32'd458299110));
    a_grant(4'b0100, 4'b0100, 1, "w3", got);
    check("w3 const", 64'(got), 64'(32'd2500872618));
    a_grant(4'b1000, 4'b1000, 1, "w4", got);

    // Round robin with all four requesting from a full FIFO
    repeat (6) @(negedge clk);
    bus_a.req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      exp_ack = 4'b0001 << (n % 4);
      check("rr ack", 64'(bus_a.ack), 64'(exp_ack));
      w = xs_next(ma);
      check("rr rdata", 64'(bus_a.rdata), 64'(w));
      bus_a.req = (n == 7) ? 4'b0000 : (4'b1111 & ~bus_a.ack);
    end
    @(negedge clk);
    a_grant(4'b1111, 4'b0001, 1, "rr ptr wrap", got);

    // All-zero staging falls back to the default seed and flags seed_err
    a_seed_write(2'd0, 32'd0);
    a_seed_write(2'd1, 32'd0);
    a_seed_write(2'd2, 32'd0);
    a_seed_write(2'd3, 32'd0);
    bus_a.req = 4'b0001;
    bus_a.seed_go = 1'b1;
    ma = DEF_SEED;
    @(negedge clk);
    bus_a.seed_go = 1'b0;
    check("zero err pulse", 64'(bus_a.seed_err), 64'(1));
    check("zero no ack 1", 64'(bus_a.ack), 64'(0));
    @(negedge clk);
    check("zero err once", 64'(bus_a.seed_err), 64'(0));
    check("zero no ack 2", 64'(bus_a.ack), 64'(0));
    @(negedge clk);
    check("zero ack", 64'(bus_a.ack), 64'(4'b0001));
    check("zero word", 64'(bus_a.rdata), 64'(32'd3701687786));
    void'(xs_next(ma));
    bus_a.req = 4'b0;

    // Staging survives seed_go: committing again still errors
    @(negedge clk);
    bus_a.seed_go = 1'b1;
    ma = DEF_SEED;
    @(negedge clk);
    bus_a.seed_go = 1'b0;
    check("zero err again", 64'(bus_a.seed_err), 64'(1));
    a_grant(4'b0010, 4'b0010, 0, "zero again", got);

    // Same-cycle write and commit: commit uses the pre-write staging
    a_seed_write(2'd0, 32'd1);
    a_seed_write(2'd1, 32'd2);
    a_seed_write(2'd2, 32'd3);
    a_seed_write(2'd3, 32'd4);
    bus_a.seed_wr = 1'b1; bus_a.seed_addr = 2'd0; bus_a.seed_data = 32'd99;
    bus_a.seed_go = 1'b1;
    ma = {32'd1, 32'd2, 32'd3, 32'd4};
    @(negedge clk);
    bus_a.seed_wr = 1'b0; bus_a.seed_go = 1'b0;
    check("prewrite no err", 64'(bus_a.seed_err), 64'(0));
    a_grant(4'b0100, 4'b0100, 0, "prewrite", got);
    bus_a.seed_go = 1'b1;
    ma = {32'd99, 32'd2, 32'd3, 32'd4};
    @(negedge clk);
    bus_a.seed_go = 1'b0;
    a_grant(4'b0001, 4'b0001, 0, "postwrite", got);

    // Reset while an ack is out and the FIFO is full
    repeat (6) @(negedge clk);
    bus_a.req = 4'b0001;
    @(posedge clk);
    #2;
    check("pending ack", 64'(bus_a.ack), 64'(4'b0001));
    reset = 1'b1;
    #1;
    check("midrst ack", 64'(bus_a.ack), 64'(0));
    check("midrst ready", 64'(bus_a.ready), 64'(0));
    check("midrst rdata", 64'(bus_a.rdata), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ma = DEF_SEED;
    mb = DEF_SEED;
    @(negedge clk);
    check("postrst no ack", 64'(bus_a.ack), 64'(0));
    @(negedge clk);
    check("postrst ack", 64'(bus_a.ack), 64'(4'b0001));
    check("postrst word", 64'(bus_a.rdata), 64'(32'd3701687786));
    void'(xs_next(ma));
    bus_a.req = 4'b0;
    // Staging was reset to the default seed as well
    @(negedge clk);
    bus_a.seed_go = 1'b1;
    ma = DEF_SEED;
    @(negedge clk);
    bus_a.seed_go = 1'b0;
    check("rst stg no err", 64'(bus_a.seed_err), 64'(0));
    a_grant(4'b0010, 4'b0010, 0, "rst stg", got);

    // Warm-up on instance B: three discarded words, busy for three cycles
    bus_b.req = 4'b0001;
    bus_b.seed_go = 1'b1;
    mb = DEF_SEED;
    repeat (3) void'(xs_next(mb));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_b.seed_go = 1'b0;
      check("warm busy", 64'(bus_b.busy), 64'(1));
      check("warm ready", 64'(bus_b.ready), 64'(0));
      check("warm no ack", 64'(bus_b.ack), 64'(0));
    end
    @(negedge clk);
    check("warm done busy", 64'(bus_b.busy), 64'(0));
    check("warm done ready", 64'(bus_b.ready), 64'(0));
    lat = 0;
    while ((bus_b.ack == 4'b0) && (lat < 10)) begin
      @(negedge clk);
      lat++;
    end
    check("warm ack", 64'(bus_b.ack), 64'(4'b0001));
    w = xs_next(mb);
    check("warm word", 64'(bus_b.rdata), 64'(w));
    bus_b.req = 4'b0;

    // Randomized requesters, seed writes and commits on instance B
    for (int i = 0; i < 4; i++) begin
      stg_b[i] = DEF_SEED[127-32*i -: 32];
      wait_cnt[i] = 0;
    end
    pend = 4'b0;
    max_wait = 0;
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      check("rnd seed_err", 64'(bus_b.seed_err), 64'(exp_err));
      if (bus_b.ack != 4'b0) begin
        check("rnd onehot", 64'($onehot(bus_b.ack)), 64'(1));
        check("rnd ack to waiting req", 64'(|(bus_b.ack & pend)), 64'(1));
        w = xs_next(mb);
        check("rnd rdata", 64'(bus_b.rdata), 64'(w));
        pend = pend & ~bus_b.ack;
      end
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end

      bus_b.seed_go = 1'b0;
      bus_b.seed_wr = 1'b0;
      exp_err = 1'b0;
      if ((cyc == 204) || ((cyc < 200 || cyc > 210) && ($urandom_range(0, 59) == 0))) begin
        bus_b.seed_go = 1'b1;
        commit = {stg_b[0], stg_b[1], stg_b[2], stg_b[3]};
        exp_err = (commit == 128'b0);
        mb = exp_err ? DEF_SEED : commit;
        repeat (3) void'(xs_next(mb));
      end
      if (cyc >= 200 && cyc < 204) begin
        bus_b.seed_wr   = 1'b1;
        bus_b.seed_addr = 2'(cyc - 200);
        bus_b.seed_data = 32'd0;
        stg_b[cyc - 200] = 32'd0;
      end else if ($urandom_range(0, 9) == 0) begin
        bus_b.seed_wr   = 1'b1;
        bus_b.seed_addr = 2'($urandom_range(0, 3));
        bus_b.seed_data = $urandom;
        stg_b[bus_b.seed_addr] = bus_b.seed_data;
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && !bus_b.ack[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          wait_cnt[i] = 0;
        end
      end
      bus_b.req = pend;
    end
    check("rnd no starvation", 64'(max_wait <= 40), 64'(1));
    bus_b.req = 4'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
